demux_8_buffered: RTL

- 1-to-8 distributor with per-channel buffering: the inverse of the 8-way 32-bit result selector.
- Routes one WIDTH-bit word, tagged with a 3-bit destination select, into one of eight single-entry output buffers.
- Every input and output uses a valid/ready handshake.
- Sits between a single producer (ALU/writeback path) and up to eight independent consumers that may stall individually.

---
 rtl/demux_8_buffered.sv | 74 +++++++
 1 files changed

// File: rtl/demux_8_buffered.sv
// rtl/demux_8_buffered.sv - 1-to-8 valid/ready distributor with a one-word buffer per channel
module demux_8_buffered #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           select,
    input  logic [WIDTH-1:0]     in_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [WIDTH-1:0]     out0,
    output logic [WIDTH-1:0]     out1,
    output logic [WIDTH-1:0]     out2,
    output logic [WIDTH-1:0]     out3,
    output logic [WIDTH-1:0]     out4,
    output logic [WIDTH-1:0]     out5,
    output logic [WIDTH-1:0]     out6,
    output logic [WIDTH-1:0]     out7,
    output logic [CNT_WIDTH-1:0] accept_count
);

    logic [7:0]           full;
    logic [WIDTH-1:0]     data_q [8];
    logic [CNT_WIDTH-1:0] count_q;
    logic [7:0]           drain;
    logic [7:0]           load;
    logic                 accept;

    // A target that drains this cycle can take a new word, so streaming has no bubble.
    always_comb begin
        in_ready = ~full[select] | out_ready[select];
        accept   = in_valid & in_ready;
        drain    = full & out_ready;
        load     = 8'h00;
        if (accept) begin
            load = 8'h01 << select;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full    <= 8'h00;
            count_q <= '0;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full <= (full & ~drain) | load;
            for (int i = 0; i < 8; i++) begin
                if (load[i]) begin
                    data_q[i] <= in_data;
                end
            end
            if (accept) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign out_valid    = full;
    assign accept_count = count_q;
    assign out0 = data_q[0];
    assign out1 = data_q[1];
    assign out2 = data_q[2];
    assign out3 = data_q[3];
    assign out4 = data_q[4];
    assign out5 = data_q[5];
    assign out6 = data_q[6];
    assign out7 = data_q[7];

endmodule
